// File: rtl/line_sensor_seq.sv
// Line-scan sensor sequencer: generates the sensor clock and ST pulse, frames
// the readout window, and counts synchronised EOC/EOS events from the sensor.
module line_sensor_seq #(
  parameter int CLK_DIV = 8,
  parameter int NPIX    = 1024,
  parameter int CW      = 24,
  parameter int PW      = $clog2(NPIX) + 1
) (
  input  logic          FPGA_CLK,
  input  logic          FPGA_RST,
  input  logic          MODE,
  input  logic          START,
  input  logic [CW-1:0] CFG_PERIOD,
  input  logic [CW-1:0] CFG_ST_HIGH,
  input  logic          CLR_ERR,
  input  logic          EOC,
  input  logic          EOS,
  output logic          SENSOR_CLK,
  output logic          ST,
  output logic          BUSY,
  output logic          PIX_STROBE,
  output logic [PW-1:0] PIX_INDEX,
  output logic          FRAME_DONE,
  output logic [PW-1:0] PIX_COUNT,
  output logic          OVERRUN,
  output logic          TIMEOUT
);

  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]   DIV_ONE  = DW'(1);
  localparam logic [CW:0]     ONE_C    = (CW+1)'(1);
  localparam logic [PW-1:0]   ONE_P    = PW'(1);
  localparam logic [PW-1:0]   NPIX_P   = PW'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ST_HI   = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  // Sensor clock divider
  logic [DW-1:0] div_cnt_q;
  logic          sclk_q;
  logic          sclk_rise;

  // Frame sequencing
  state_t        state_q;
  logic          start_lat_q;
  logic          st_q;
  logic          busy_q;
  logic [CW:0]   fcnt_q;
  logic [CW:0]   fcnt_inc;
  logic [CW:0]   st_high_q;
  logic [CW:0]   period_q;
  logic [CW:0]   st_eff;
  logic [CW:0]   per_eff;
  logic          frame_start;
  logic          frame_end;

  // Sensor input synchronisers and edge detectors
  logic          eoc_ff1_q, eoc_ff2_q, eoc_prev_q, eoc_edge_q;
  logic          eos_ff1_q, eos_ff2_q, eos_prev_q, eos_edge_q;

  // Pixel accounting
  logic [PW-1:0] pix_cnt_q;
  logic [PW-1:0] cnt_after;
  logic [PW-1:0] pix_index_q;
  logic [PW-1:0] pix_count_q;
  logic          pix_strobe_q;
  logic          frame_done_q;
  logic          eos_seen_q;
  logic          overrun_q;
  logic          timeout_q;
  logic          in_frame;
  logic          eoc_acc;
  logic          eoc_over;
  logic          eos_first;
  logic          timeout_set;

  // sclk_rise marks the cycle whose clock edge drives SENSOR_CLK from 0 to 1;
  // it is the only timebase the frame counters use.
  assign sclk_rise = (div_cnt_q == DIV_LAST) && !sclk_q;

  // Free-running divider; SENSOR_CLK is a data output, never a clock here
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
      sclk_q    <= ~sclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_ONE;
    end
  end

  // Config sanitising: ST_HIGH is at least 1, PERIOD strictly exceeds ST_HIGH.
  // One extra bit keeps ST_HIGH+1 from wrapping at the top of the CW range.
  always_comb begin
    st_eff  = (CFG_ST_HIGH == '0) ? ONE_C : {1'b0, CFG_ST_HIGH};
    per_eff = ({1'b0, CFG_PERIOD} <= st_eff) ? (st_eff + ONE_C) : {1'b0, CFG_PERIOD};
  end

  assign fcnt_inc    = fcnt_q + ONE_C;
  assign frame_end   = (state_q == S_READOUT) && sclk_rise && (fcnt_inc == period_q);
  assign frame_start = sclk_rise &&
                       (((state_q == S_IDLE) && (MODE || start_lat_q)) ||
                        (frame_end && MODE));

  // Frame FSM with registered ST/BUSY; frame counter counts sclk_rise since ST_HI entry
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state_q     <= S_IDLE;
      start_lat_q <= 1'b0;
      st_q        <= 1'b0;
      busy_q      <= 1'b0;
      fcnt_q      <= '0;
    end else if (frame_start) begin
      state_q     <= S_ST_HI;
      start_lat_q <= 1'b0;
      st_q        <= 1'b1;
      busy_q      <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) start_lat_q <= 1'b1;
        end
        S_ST_HI: begin
          if (sclk_rise) begin
            fcnt_q <= fcnt_inc;
            if (fcnt_inc == st_high_q) begin
              state_q <= S_READOUT;
              st_q    <= 1'b0;
            end
          end
        end
        S_READOUT: begin
          if (frame_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
          end else if (sclk_rise) begin
            fcnt_q <= fcnt_inc;
          end
        end
        default: begin
          state_q <= S_IDLE;
          st_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Frame config snapshot; only read while a frame is running
  always_ff @(posedge FPGA_CLK) begin
    if (frame_start) begin
      st_high_q <= st_eff;
      period_q  <= per_eff;
    end
  end

  // Two-flop synchronisers followed by registered rising-edge detectors
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      eoc_ff1_q  <= 1'b0;
      eoc_ff2_q  <= 1'b0;
      eoc_prev_q <= 1'b0;
      eoc_edge_q <= 1'b0;
      eos_ff1_q  <= 1'b0;
      eos_ff2_q  <= 1'b0;
      eos_prev_q <= 1'b0;
      eos_edge_q <= 1'b0;
    end else begin
      eoc_ff1_q  <= EOC;
      eoc_ff2_q  <= eoc_ff1_q;
      eoc_prev_q <= eoc_ff2_q;
      eoc_edge_q <= eoc_ff2_q & ~eoc_prev_q;
      eos_ff1_q  <= EOS;
      eos_ff2_q  <= eos_ff1_q;
      eos_prev_q <= eos_ff2_q;
      eos_edge_q <= eos_ff2_q & ~eos_prev_q;
    end
  end

  // An EOC coinciding with EOS is folded into cnt_after before PIX_COUNT latches
  assign in_frame    = (state_q != S_IDLE);
  assign eoc_acc     = eoc_edge_q && in_frame && (pix_cnt_q != NPIX_P);
  assign eoc_over    = eoc_edge_q && in_frame && (pix_cnt_q == NPIX_P);
  assign cnt_after   = eoc_acc ? (pix_cnt_q + ONE_P) : pix_cnt_q;
  assign eos_first   = eos_edge_q && in_frame && !eos_seen_q;
  assign timeout_set = frame_end && !eos_seen_q && !eos_first;

  // Pixel counting, frame completion and sticky error flags (set beats clear)
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      pix_cnt_q    <= '0;
      pix_index_q  <= '0;
      pix_count_q  <= '0;
      pix_strobe_q <= 1'b0;
      frame_done_q <= 1'b0;
      eos_seen_q   <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      pix_strobe_q <= eoc_acc;
      frame_done_q <= eos_first;
      if (eoc_acc) pix_index_q <= pix_cnt_q;
      if (eos_first || timeout_set) pix_count_q <= cnt_after;
      if (frame_start) begin
        pix_cnt_q  <= '0;
        eos_seen_q <= 1'b0;
      end else begin
        pix_cnt_q <= cnt_after;
        if (eos_first) eos_seen_q <= 1'b1;
      end
      if (eoc_over)     overrun_q <= 1'b1;
      else if (CLR_ERR) overrun_q <= 1'b0;
      if (timeout_set)  timeout_q <= 1'b1;
      else if (CLR_ERR) timeout_q <= 1'b0;
    end
  end

  assign SENSOR_CLK = sclk_q;
  assign ST         = st_q;
  assign BUSY       = busy_q;
  assign PIX_STROBE = pix_strobe_q;
  assign PIX_INDEX  = pix_index_q;
  assign FRAME_DONE = frame_done_q;
  assign PIX_COUNT  = pix_count_q;
  assign OVERRUN    = overrun_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_line_sensor_seq.sv
// Scoreboard bench for line_sensor_seq: stimulus pushes expected strobes and
// frame completions; a negedge monitor pops and compares them.
module tb_line_sensor_seq;

  localparam int CLK_DIV = 2;
  localparam int NPIX    = 8;
  localparam int CW      = 24;
  localparam int PW      = $clog2(NPIX) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic          clr_err = 1'b0;
  logic          eoc = 1'b0;
  logic          eos = 1'b0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_st_high = '0;
  logic          sclk, st, busy, pix_strobe, frame_done, overrun, timeout;
  logic [PW-1:0] pix_index, pix_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    int value;
    int cycle;
  } exp_t;
  exp_t sbq[$];

  line_sensor_seq #(
    .CLK_DIV(CLK_DIV),
    .NPIX   (NPIX),
    .CW     (CW),
    .PW     (PW)
  ) dut (
    .FPGA_CLK   (clk),
    .FPGA_RST   (rst),
    .MODE       (mode),
    .START      (start),
    .CFG_PERIOD (cfg_period),
    .CFG_ST_HIGH(cfg_st_high),
    .CLR_ERR    (clr_err),
    .EOC        (eoc),
    .EOS        (eos),
    .SENSOR_CLK (sclk),
    .ST         (st),
    .BUSY       (busy),
    .PIX_STROBE (pix_strobe),
    .PIX_INDEX  (pix_index),
    .FRAME_DONE (frame_done),
    .PIX_COUNT  (pix_count),
    .OVERRUN    (overrun),
    .TIMEOUT    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe / frame-done must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (pix_strobe) begin
      if (sbq.size() == 0 || sbq[0].is_done) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got index %0d at cycle %0d expected none", pix_index, cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_index", pix_index, e.value);
        chk("strobe_cycle", cyc, e.cycle);
      end
    end
    if (frame_done) begin
      if (sbq.size() == 0 || !sbq[0].is_done) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done: got pix_count %0d at cycle %0d expected none", pix_count, cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_pix_count", pix_count, e.value);
        chk("done_cycle", cyc, e.cycle);
      end
    end
  end

  task automatic push_exp(input bit is_done, input int value, input int cycle);
    exp_t e;
    e.is_done = is_done;
    e.value   = value;
    e.cycle   = cycle;
    sbq.push_back(e);
  endtask

  // Input goes high at a negedge: first sampling edge is cyc+1, output registered at cyc+4
  task automatic eoc_pulse(input bit expect_strobe, input int idx);
    @(negedge clk);
    eoc = 1'b1;
    if (expect_strobe) push_exp(1'b0, idx, cyc + 4);
    repeat (2) @(negedge clk);
    eoc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic eos_pulse(input bit expect_done, input int count);
    @(negedge clk);
    eos = 1'b1;
    if (expect_done) push_exp(1'b1, count, cyc + 4);
    repeat (2) @(negedge clk);
    eos = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int max_cyc, input string name);
    int n = 0;
    while (busy !== level && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, level);
  endtask

  task automatic frame_counts(output int st_n, output int busy_n);
    int n = 0;
    st_n = 0;
    busy_n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (busy && busy_n < 2000) begin
      st_n += int'(st);
      busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sclk"},       sclk, 0);
    chk({tag, "_st"},         st, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_pix_strobe"}, pix_strobe, 0);
    chk({tag, "_pix_index"},  pix_index, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pix_count"},  pix_count, 0);
    chk({tag, "_overrun"},    overrun, 0);
    chk({tag, "_timeout"},    timeout, 0);
  endtask

  task automatic idle_hold(input string name);
    int busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busy_seen += int'(busy);
    end
    chk(name, busy_seen, 0);
  endtask

  initial begin
    int r1, r2, st_n, busy_n, rises, drops, n;
    logic prev;

    // Reset state
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Sensor clock period: CLK_DIV=2 gives 4 FPGA cycles
    r1 = -1;
    r2 = -1;
    prev = sclk;
    for (int i = 0; i < 20 && r2 < 0; i++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
      prev = sclk;
    end
    chk("sclk_period", r2 - r1, 4);

    // Single-shot frame timing, no sensor activity
    cfg_period  = 24'd20;
    cfg_st_high = 24'd4;
    mode        = 1'b0;
    pulse_start();
    frame_counts(st_n, busy_n);
    chk("a_st_cycles", st_n, 16);
    chk("a_busy_cycles", busy_n, 80);
    chk("a_timeout", timeout, 1);
    idle_hold("a_idle_after");
    pulse_clr();
    chk("a_timeout_cleared", timeout, 0);

    // Five pixels then EOS; a START mid-frame must be ignored
    cfg_period = 24'd30;
    pulse_start();
    wait_busy(1'b1, 20, "b_busy_rise");
    pulse_start();
    for (int i = 0; i < 5; i++) eoc_pulse(1'b1, i);
    eos_pulse(1'b1, 5);
    wait_busy(1'b0, 200, "b_busy_fall");
    chk("b_pix_count", pix_count, 5);
    chk("b_timeout", timeout, 0);
    chk("b_overrun", overrun, 0);
    idle_hold("b_start_ignored");

    // Ten pixels against NPIX=8
    pulse_start();
    wait_busy(1'b1, 20, "c_busy_rise");
    for (int i = 0; i < 8; i++) eoc_pulse(1'b1, i);
    chk("c_overrun_before", overrun, 0);
    eoc_pulse(1'b0, 0);
    chk("c_overrun_after9", overrun, 1);
    eoc_pulse(1'b0, 0);
    eos_pulse(1'b1, 8);
    wait_busy(1'b0, 200, "c_busy_fall");
    chk("c_overrun_sticky", overrun, 1);
    chk("c_pix_count", pix_count, 8);
    pulse_clr();
    chk("c_overrun_cleared", overrun, 0);

    // Continuous mode without EOS
    cfg_period  = 24'd3;
    cfg_st_high = 24'd1;
    mode        = 1'b1;
    wait_busy(1'b1, 20, "d_busy_rise");
    rises = 0;
    drops = 0;
    prev  = st;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (!busy) drops++;
      if (st && !prev) rises++;
      prev = st;
    end
    chk("d_busy_drops", drops, 0);
    chk("d_many_frames", rises >= 3, 1);
    chk("d_timeout", timeout, 1);
    n = 0;
    prev = st;
    @(negedge clk);
    while (!(st && !prev) && n < 30) begin
      prev = st;
      @(negedge clk);
      n++;
    end
    mode = 1'b0;
    busy_n = 0;
    while (busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    chk("d_last_frame_cycles", busy_n, 12);
    idle_hold("d_idle_after_mode0");

    // Degenerate config: ST_HIGH=0, PERIOD=0
    pulse_clr();
    cfg_period  = 24'd0;
    cfg_st_high = 24'd0;
    pulse_start();
    frame_counts(st_n, busy_n);
    chk("e_st_cycles", st_n, 4);
    chk("e_busy_cycles", busy_n, 8);
    chk("e_timeout", timeout, 1);

    // Reset during READOUT
    cfg_period  = 24'd20;
    cfg_st_high = 24'd4;
    pulse_start();
    wait_busy(1'b1, 20, "f_busy_rise");
    n = 0;
    while (st && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("f_in_readout", st, 0);
    eoc_pulse(1'b1, 0);
    eoc_pulse(1'b1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    eos_pulse(1'b0, 0);
    idle_hold("f_idle_after_reset");
    pulse_start();
    wait_busy(1'b1, 20, "f2_busy_rise");
    for (int i = 0; i < 3; i++) eoc_pulse(1'b1, i);
    eos_pulse(1'b1, 3);
    wait_busy(1'b0, 200, "f2_busy_fall");
    chk("f2_pix_count", pix_count, 3);
    chk("f2_timeout", timeout, 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_sensor_seq.md
LINE_SENSOR_SEQ -- requirements
Module: line_sensor_seq

Interface
REQ-001 Parameter CLK_DIV, default 8: FPGA_CLK cycles per SENSOR_CLK half-period; legal range >= 1.
REQ-002 Parameter NPIX, default 1024: maximum pixels accepted per frame.
REQ-003 Parameter CW, default 24: width of the frame-timing config inputs.
REQ-004 Parameter PW, default clog2(NPIX)+1: width of the pixel index and pixel count.
REQ-005 The block has one clock; reset is synchronous and active-high.
REQ-006 FPGA_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 FPGA_RST  in  1  synchronous, active-high reset.
REQ-008 MODE  in  1  0 = single-shot, 1 = continuous.
REQ-009 START  in  1  single-cycle pulse that requests one frame in single-shot mode.
REQ-010 CFG_PERIOD  in  CW  frame period, in SENSOR_CLK cycles.
REQ-011 CFG_ST_HIGH  in  CW  ST high time, in SENSOR_CLK cycles.
REQ-012 CLR_ERR  in  1  pulse that clears the sticky error flags.
REQ-013 EOC  in  1  asynchronous sensor end-of-conversion input.
REQ-014 EOS  in  1  asynchronous sensor end-of-scan input.
REQ-015 SENSOR_CLK  out  1  registered sensor drive clock.
REQ-016 ST  out  1  registered sensor start pulse.
REQ-017 BUSY  out  1  high in any state other than IDLE.
REQ-018 PIX_STROBE  out  1  one-cycle pulse per accepted pixel.
REQ-019 PIX_INDEX  out  PW  0-based index of the pixel, valid while PIX_STROBE is high.
REQ-020 FRAME_DONE  out  1  one-cycle pulse on the first EOS of a frame.
REQ-021 PIX_COUNT  out  PW  pixels accepted in the last completed frame.
REQ-022 OVERRUN  out  1  sticky flag: EOC arrived beyond NPIX pixels.
REQ-023 TIMEOUT  out  1  sticky flag: a frame ended without EOS.

Function
REQ-024 SENSOR_CLK generation:
- A divider counter runs 0..CLK_DIV-1 and toggles SENSOR_CLK on reaching CLK_DIV-1.
- The internal enable sclk_rise is high for the one FPGA_CLK cycle in which SENSOR_CLK goes 0->1.
- SENSOR_CLK is never used as a clock inside the block.
REQ-025 All frame-timing counters advance only when sclk_rise is high.
REQ-026 FSM state IDLE:
- ST=0.
- Moves to ST_HI on sclk_rise when MODE=1, or when a START pulse has been latched.
- START is latched in IDLE and held until consumed.
- START arriving outside IDLE is ignored.
REQ-027 On entry to ST_HI:
- CFG_PERIOD and CFG_ST_HIGH are sampled into internal registers; config changes mid-frame have no effect.
- The pixel counter clears to 0.
- The EOS-seen flag clears.
REQ-028 Config sanitising at the sampling point:
- CFG_ST_HIGH=0 is treated as 1.
- CFG_PERIOD <= effective ST_HIGH is treated as effective ST_HIGH+1.
REQ-029 FSM state ST_HI: ST=1 for exactly ST_HIGH sclk_rise events, then the FSM moves to READOUT.
REQ-030 FSM state READOUT:
- ST=0 until PERIOD sclk_rise events have elapsed since ST_HI entry.
- It then moves to ST_HI if MODE=1, otherwise to IDLE.
REQ-031 EOC and EOS each pass through a 2-FF synchroniser followed by a rising-edge detector.
REQ-032 PIX_STROBE latency: PIX_STROBE asserts on the 3rd FPGA_CLK rising edge after EOC is first sampled high, for exactly 1 cycle.
REQ-033 On each accepted EOC edge:
- PIX_INDEX is set to the current pixel count.
- The pixel count then increments.
REQ-034 Pixel limit:
- An EOC edge arriving when the count equals NPIX produces no strobe.
- The count holds at NPIX.
- OVERRUN is set.
REQ-035 EOC edges in IDLE are ignored and do not set OVERRUN.
REQ-036 On the first EOS edge in ST_HI or READOUT:
- FRAME_DONE pulses for 1 cycle.
- PIX_COUNT latches the pixel count.
- Later EOS edges in the same frame are ignored.
REQ-037 Simultaneous EOC and EOS sync edges: the EOC is counted first, and PIX_COUNT includes that pixel.
REQ-038 If READOUT ends with no EOS seen:
- TIMEOUT is set.
- PIX_COUNT latches the pixel count.
- FRAME_DONE does not pulse.
REQ-039 OVERRUN and TIMEOUT clear only on FPGA_RST or CLR_ERR; if a set condition coincides with CLR_ERR, the set wins.
REQ-040 The PW counters do not wrap; all CW counters compare as unsigned values.

Reset
REQ-041 While FPGA_RST=1, all of the following are forced to 0:
- outputs: SENSOR_CLK, ST, BUSY, PIX_STROBE, PIX_INDEX, FRAME_DONE, PIX_COUNT, OVERRUN, TIMEOUT;
- internal state: divider counter, synchroniser FFs, latched START.
REQ-042 While FPGA_RST=1, the FSM is in IDLE.
REQ-043 Reset asserted mid-frame aborts the frame in the next cycle with no FRAME_DONE pulse; the block resumes from IDLE.

Verification
REQ-044 Setup: CLK_DIV=2, MODE=0, CFG_PERIOD=20, CFG_ST_HIGH=4, one START pulse.
- Expect SENSOR_CLK period of 4 FPGA_CLK cycles.
- Expect ST high for 16 FPGA_CLK cycles.
- Expect BUSY for 80 cycles, then IDLE.
REQ-045 Setup: NPIX=8, 5 EOC pulses, then EOS.
- Expect 5 PIX_STROBE pulses with PIX_INDEX 0..4.
- Expect a FRAME_DONE pulse with PIX_COUNT=5.
- Expect each strobe 3 cycles after its EOC rise.
REQ-046 Setup: NPIX=8, 10 EOC pulses in one frame.
- Expect 8 strobes.
- Expect OVERRUN=1 after the 9th EOC.
- Expect CLR_ERR to clear OVERRUN.
REQ-047 Setup: MODE=1, no EOS.
- Expect back-to-back frames.
- Expect TIMEOUT=1 after the first frame and FRAME_DONE never asserted.
- Setting MODE=0 mid-frame completes the current frame, then enters IDLE.
REQ-048 Setup: CFG_ST_HIGH=0, CFG_PERIOD=0.
- Expect ST high for 1 SENSOR_CLK cycle and a frame of 2 SENSOR_CLK cycles.
REQ-049 Setup: FPGA_RST pulse during READOUT.
- Expect all outputs 0 in the next cycle and no FRAME_DONE.
- A new START runs a normal frame.
